hilo_acc: RTL and testbench

- Parametrised successor to the plain HI/LO register pair.
- Holds the HI/LO architectural registers. Supports independent writes of HI and LO (MTHI/MTLO), full pair writes (MULT/DIV results), and optional two-cycle multiply-accumulate/subtract of a 2×DATA_W product into {HI,LO} (MADD/MSUB).
- Sits in the write-back stage beside the register file; the EX-stage multiplier supplies products.

---
 rtl/hilo_pkg.sv | 25 ++
 rtl/hilo_acc.sv | 143 ++++++++++++++
 tb/tb_hilo_acc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes, op width and FSM state encoding shared by hilo_acc.
package hilo_pkg;

    localparam int HILO_OP_W = 3;

    typedef logic [HILO_OP_W-1:0] hilo_op_t;

    localparam hilo_op_t HILO_OP_NOP   = 3'd0;
    localparam hilo_op_t HILO_OP_WRITE = 3'd1;
    localparam hilo_op_t HILO_OP_MTHI  = 3'd2;
    localparam hilo_op_t HILO_OP_MTLO  = 3'd3;
    localparam hilo_op_t HILO_OP_MADD  = 3'd4;
    localparam hilo_op_t HILO_OP_MSUB  = 3'd5;

    typedef enum logic {
        HILO_IDLE = 1'b0,
        HILO_ACC  = 1'b1
    } hilo_state_e;

    // True for the two-cycle accumulate ops (MADD/MSUB).
    function automatic logic hilo_is_acc_op(input hilo_op_t op);
        return (op == HILO_OP_MADD) || (op == HILO_OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO architectural register pair with single-cycle writes
// (WRITE/MTHI/MTLO) and an optional two-cycle multiply-accumulate/subtract
// of a 2*DATA_W product into {HI,LO}.
//
// Build option: define HILO_ACC_EN to include MADD/MSUB and the FSM.
// Without it, op codes 4-5 are NOPs and busy/done are tied low.
//
// Handshake: an op is taken on a rising edge when op_valid && !busy && !flush;
// while busy is high the requester holds op/op_valid/data unchanged and the
// op is taken on the first edge after busy drops. There is no backpressure
// beyond busy and no response channel other than done.
module hilo_acc
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              accept;
    logic              commit;
    logic [DATA_W-1:0] hi_acc_res;
    logic [DATA_W-1:0] lo_acc_res;

    assign accept = op_valid && !busy && !flush;

`ifdef HILO_ACC_EN

    hilo_state_e       state_q;
    hilo_state_e       state_d;
    logic [DATA_W-1:0] tmp_hi;
    logic [DATA_W-1:0] tmp_lo;
    logic              tmp_c;
    logic              is_sub;
    logic [DATA_W-1:0] b_lo_eff;
    logic [DATA_W:0]   lo_sum;
    logic              acc_start;

    // Low half of the accumulate: one DATA_W+1-bit add whose top bit is the
    // carry into HI. MSUB is lo + ~B_lo + 1 (two's complement of B).
    always_comb begin
        is_sub    = (op == HILO_OP_MSUB);
        b_lo_eff  = is_sub ? ~lo_wdata : lo_wdata;
        lo_sum    = {1'b0, lo_q} + {1'b0, b_lo_eff} + {{DATA_W{1'b0}}, is_sub};
        acc_start = accept && hilo_is_acc_op(op);
    end

    // Next-state and status outputs; rst suppresses the done pulse.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            HILO_IDLE: begin
                if (acc_start) state_d = HILO_ACC;
            end
            HILO_ACC: begin
                busy    = 1'b1;
                done    = !flush && !rst;
                commit  = !flush;
                state_d = HILO_IDLE;
            end
            default: state_d = HILO_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HILO_IDLE;
        else     state_q <= state_d;
    end

    // Latch the low partial sum, its carry and the (possibly inverted) B_hi.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmp_hi <= '0;
            tmp_lo <= '0;
            tmp_c  <= 1'b0;
        end else if (acc_start) begin
            tmp_lo <= lo_sum[DATA_W-1:0];
            tmp_c  <= lo_sum[DATA_W];
            tmp_hi <= is_sub ? ~hi_wdata : hi_wdata;
        end
    end

    // High half of the accumulate, finished in the ACC cycle.
    always_comb begin
        hi_acc_res = hi_q + tmp_hi + {{(DATA_W-1){1'b0}}, tmp_c};
        lo_acc_res = tmp_lo;
    end

`else

    // Accumulate path absent: never busy, never commits.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        commit     = 1'b0;
        hi_acc_res = hi_q;
        lo_acc_res = lo_q;
    end

`endif

    // HI/LO registers: an accumulate commit updates both atomically; otherwise
    // an accepted write op updates its target register(s).
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= hi_acc_res;
            lo_q <= lo_acc_res;
        end else if (accept) begin
            case (op)
                HILO_OP_WRITE: begin
                    hi_q <= hi_wdata;
                    lo_q <= lo_wdata;
                end
                HILO_OP_MTHI: hi_q <= hi_wdata;
                HILO_OP_MTLO: lo_q <= lo_wdata;
                default: ;
            endcase
        end
    end

    assign hi_rdata = hi_q;
    assign lo_rdata = lo_q;

endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: directed vectors for hilo_acc with a queue-based scoreboard.
// Expectations adapt to whether HILO_ACC_EN is defined for the build.
module tb_hilo_acc;
    import hilo_pkg::*;

    localparam int DW    = 32;
    localparam int TAG_W = 16;
    localparam int EXP_W = TAG_W + 1 + 2*DW + 2;

`ifdef HILO_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic [2:0]    op;
    logic [DW-1:0] hi_wdata;
    logic [DW-1:0] lo_wdata;
    logic          flush;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi_rdata;
    logic [DW-1:0] lo_rdata;

    logic [EXP_W-1:0] exp_q[$];
    int               neg_cnt = 0;
    int               checks  = 0;
    int               errors  = 0;

    hilo_acc #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic v, input logic [2:0] o,
                         input logic [DW-1:0] h, input logic [DW-1:0] l,
                         input logic f);
        @(posedge clk);
        #1;
        rst = r; op_valid = v; op = o; hi_wdata = h; lo_wdata = l; flush = f;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, HILO_OP_NOP, 32'h0, 32'h0, 1'b0);
    endtask

    // Expected outputs for the cycle just driven (sampled at its negedge).
    task automatic expect_now(input logic [DW-1:0] h, input logic [DW-1:0] l,
                              input logic b, input logic d, input logic chk_bd);
        logic [TAG_W-1:0] tag;
        tag = TAG_W'(neg_cnt + 1);
        exp_q.push_back({tag, chk_bd, h, l, b, d});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        neg_cnt = neg_cnt + 1;
        while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: TAG_W]) == neg_cnt) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (hi_rdata !== e[2*DW+1 : DW+2]) begin
                errors = errors + 1;
                $display("FAIL hi cyc=%0d got=%h want=%h", neg_cnt, hi_rdata, e[2*DW+1 : DW+2]);
            end
            checks = checks + 1;
            if (lo_rdata !== e[DW+1 : 2]) begin
                errors = errors + 1;
                $display("FAIL lo cyc=%0d got=%h want=%h", neg_cnt, lo_rdata, e[DW+1 : 2]);
            end
            if (e[2*DW+2]) begin
                checks = checks + 1;
                if (busy !== e[1]) begin
                    errors = errors + 1;
                    $display("FAIL busy cyc=%0d got=%b want=%b", neg_cnt, busy, e[1]);
                end
                checks = checks + 1;
                if (done !== e[0]) begin
                    errors = errors + 1;
                    $display("FAIL done cyc=%0d got=%b want=%b", neg_cnt, done, e[0]);
                end
            end
        end
    end

    // Run an accumulate from preload (ph,pl) with operand (bh,bl) and check
    // the in-flight cycle and the result (rh,rl).
    task automatic acc_case(input logic [2:0] o,
                            input logic [DW-1:0] ph, input logic [DW-1:0] pl,
                            input logic [DW-1:0] bh, input logic [DW-1:0] bl,
                            input logic [DW-1:0] rh, input logic [DW-1:0] rl);
        drive(1'b0, 1'b1, HILO_OP_WRITE, ph, pl, 1'b0);
        drive(1'b0, 1'b1, o, bh, bl, 1'b0);
        expect_now(ph, pl, 1'b0, 1'b0, 1'b1);
        idle();
        expect_now(ph, pl, ACC_EN, ACC_EN, 1'b1);
        idle();
        expect_now(ACC_EN ? rh : ph, ACC_EN ? rl : pl, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; op_valid = 1'b0; op = HILO_OP_NOP;
        hi_wdata = '0; lo_wdata = '0; flush = 1'b0;
        drive(1'b1, 1'b0, HILO_OP_NOP, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, HILO_OP_NOP, 32'h0, 32'h0, 1'b0);

        // Reset state.
        idle();
        expect_now(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // WRITE then MTLO; no bypass, so each shows a cycle later.
        drive(1'b0, 1'b1, HILO_OP_WRITE, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        expect_now(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, HILO_OP_MTLO, 32'hDEADBEEF, 32'h00000001, 1'b0);
        expect_now(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, HILO_OP_MTHI, 32'h0000CAFE, 32'hFFFF0000, 1'b0);
        expect_now(32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b1);
        idle();
        expect_now(32'h0000CAFE, 32'h00000001, 1'b0, 1'b0, 1'b1);

        // Flush in IDLE drops a same-cycle WRITE; codes 6/7 are NOPs.
        drive(1'b0, 1'b1, HILO_OP_WRITE, 32'h55, 32'h66, 1'b1);
        drive(1'b0, 1'b1, 3'd6, 32'h77, 32'h88, 1'b0);
        expect_now(32'h0000CAFE, 32'h00000001, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 3'd7, 32'h99, 32'hAA, 1'b0);
        expect_now(32'h0000CAFE, 32'h00000001, 1'b0, 1'b0, 1'b1);
        idle();
        expect_now(32'h0000CAFE, 32'h00000001, 1'b0, 1'b0, 1'b1);

        // Carry propagation, borrow, and mixed carry cases.
        acc_case(HILO_OP_MADD, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1, 32'h0);
        acc_case(HILO_OP_MSUB, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF);
        acc_case(HILO_OP_MADD, 32'h1, 32'h80000000, 32'h10, 32'h80000001, 32'h12, 32'h1);
        acc_case(HILO_OP_MSUB, 32'h5, 32'h3, 32'h2, 32'h1, 32'h3, 32'h2);
        acc_case(HILO_OP_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 32'h0);

        // Flush in the ACC cycle: no commit, no done, idle next cycle.
        drive(1'b0, 1'b1, HILO_OP_WRITE, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, HILO_OP_MADD, 32'h5, 32'h7, 1'b0);
        drive(1'b0, 1'b0, HILO_OP_NOP, 32'h0, 32'h0, 1'b1);
        expect_now(32'h0, 32'h0, ACC_EN, 1'b0, 1'b1);
        idle();
        expect_now(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle();
        expect_now(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset during ACC clears everything.
        drive(1'b0, 1'b1, HILO_OP_WRITE, 32'h3, 32'h4, 1'b0);
        drive(1'b0, 1'b1, HILO_OP_MADD, 32'h1, 32'h1, 1'b0);
        drive(1'b1, 1'b0, HILO_OP_NOP, 32'h0, 32'h0, 1'b0);
        expect_now(32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        idle();
        expect_now(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // MTHI held while busy is applied only after busy drops.
        drive(1'b0, 1'b1, HILO_OP_WRITE, 32'h10, 32'h20, 1'b0);
        drive(1'b0, 1'b1, HILO_OP_MADD, 32'h0, 32'h1, 1'b0);
        drive(1'b0, 1'b1, HILO_OP_MTHI, 32'hAA, 32'h0, 1'b0);
        expect_now(32'h10, 32'h20, ACC_EN, ACC_EN, 1'b1);
        drive(1'b0, 1'b1, HILO_OP_MTHI, 32'hAA, 32'h0, 1'b0);
        expect_now(ACC_EN ? 32'h10 : 32'hAA, ACC_EN ? 32'h21 : 32'h20, 1'b0, 1'b0, 1'b1);
        idle();
        expect_now(32'hAA, ACC_EN ? 32'h21 : 32'h20, 1'b0, 1'b0, 1'b1);

        idle();
        idle();
        idle();
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
